// File: rtl/n5_uart_pkg.sv
// Shared definitions for the n5_uart_tx slice: FSM encoding and frame constants.
// N5_UART_PARITY_EN adds the PARITY state.
package n5_uart_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3
`ifdef N5_UART_PARITY_EN
      ,
      PARITY = 3'd4
`endif
   } state_t;

endpackage

// File: rtl/n5_sync_fifo.sv
// Synchronous FIFO with push/pop, full/empty and an explicit occupancy count.
// Occupancy is kept separately from the pointers so full and empty stay distinct.
module n5_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (level == FULL_LEVEL);
   assign empty    = (level == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/n5_uart_tx.sv
// 8N1 UART transmitter with byte FIFO; FSM, baud counter and shifter live here.
// Define N5_UART_PARITY_EN to add the parity_odd port and a parity bit per frame.
module n5_uart_tx
   import n5_uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic                          en,
   input  logic [PRESCALE_W-1:0]         prescale,
   input  logic [7:0]                    wdata,
   input  logic                          wvalid,
`ifdef N5_UART_PARITY_EN
   input  logic                          parity_odd,
`endif
   output logic                          wready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          done
);

   state_t                  state, state_d;
   logic [PRESCALE_W-1:0]   cnt, cnt_d;
   logic [PRESCALE_W-1:0]   presc, presc_d;
   logic [BIT_IDX_W-1:0]    idx, idx_d;
   logic [7:0]              shift, shift_d;
   logic                    par, par_d;
   logic                    tx_d, busy_d, done_d;
   logic                    pop;
   logic                    full, empty;
   logic [7:0]              fifo_data;

   assign wready = !full;

   n5_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .push      (wvalid),
      .push_data (wdata),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         cnt   <= '0;
         presc <= '0;
         idx   <= '0;
         shift <= '0;
         par   <= 1'b0;
         tx    <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         presc <= presc_d;
         idx   <= idx_d;
         shift <= shift_d;
         par   <= par_d;
         tx    <= tx_d;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      presc_d = presc;
      idx_d   = idx;
      shift_d = shift;
      par_d   = par;
      pop     = 1'b0;

      unique case (state)
         IDLE: begin
            if (en && !empty) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (cnt == '0) begin
               state_d = DATA;
               idx_d   = '0;
               cnt_d   = presc;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         DATA: begin
            if (cnt == '0) begin
               shift_d = shift >> 1;
               cnt_d   = presc;
               if (idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef N5_UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx + 1'b1;
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
`ifdef N5_UART_PARITY_EN
         PARITY: begin
            if (cnt == '0) begin
               state_d = STOP;
               cnt_d   = presc;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
`endif
         STOP: begin
            if (cnt == '0) begin
               if (en && !empty) begin
                  pop     = 1'b1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame start: prescale (and parity sense) are captured once per frame.
      if (pop) begin
         shift_d = fifo_data;
         cnt_d   = prescale;
         presc_d = prescale;
`ifdef N5_UART_PARITY_EN
         par_d   = (^fifo_data) ^ parity_odd;
`endif
      end
   end

   always_comb begin
      tx_d = 1'b1;
      unique case (state)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift[0];
`ifdef N5_UART_PARITY_EN
         PARITY:  tx_d = par;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state != IDLE);
      done_d = (state == STOP) && (cnt == '0);
   end

endmodule

// File: tb/tb_n5_uart_tx.sv
// Self-checking bench for n5_uart_tx: directed steps with randomized bytes and prescales,
// compared against a frame-level model (bit list per byte, byte queue for ordering).
module tb_n5_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] prescale = 16'd15;
   logic [7:0]  wdata = '0;
   logic        wvalid = 1'b0;
   logic        parity_odd = 1'b0;
   logic        wready, tx, busy, done;
   logic [4:0]  level;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   n5_uart_tx #(
      .FIFO_DEPTH (16),
      .PRESCALE_W (16)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .en         (en),
      .prescale   (prescale),
      .wdata      (wdata),
      .wvalid     (wvalid),
`ifdef N5_UART_PARITY_EN
      .parity_odd (parity_odd),
`endif
      .wready     (wready),
      .tx         (tx),
      .busy       (busy),
      .level      (level),
      .done       (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      wdata  = b;
      wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
   endtask

   // Line must stay high (no frame) for n clocks.
   task automatic idle_check(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
         @(negedge clk);
      end
      check(tag, bad, 0);
   endtask

   // Checks one whole frame clock by clock. At clock chg_at of the frame,
   // prescale/en are driven to chg_p/chg_en to exercise mid-frame changes.
   task automatic expect_frame(input logic [7:0] b, input int p, input bit immediate,
                               input int chg_at, input logic [15:0] chg_p, input logic chg_en);
      logic bits[$];
      logic [7:0] rx = '0;
      int n = 0;
      int clk_i = 0;
      int done_bad = 0;
      int busy_bad = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef N5_UART_PARITY_EN
      bits.push_back((^b) ^ parity_odd);
`endif
      bits.push_back(1'b1);
      if (immediate) check("b2b_no_gap", tx, 0);
      while (tx !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("frame_start_seen", (n < 5000), 1);
      for (int k = 0; k < bits.size(); k++) begin
         int bad = 0;
         for (int c = 0; c <= p; c++) begin
            if (tx !== bits[k]) bad++;
            if (done !== ((k == bits.size() - 1) && (c == p))) done_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (k >= 1 && k <= 8 && c == p / 2) rx[k-1] = tx;
            clk_i++;
            if (clk_i == chg_at) begin
               prescale = chg_p;
               en       = chg_en;
            end
            @(negedge clk);
         end
         check($sformatf("byte%02h_bit%0d", b, k), bad, 0);
      end
      check($sformatf("byte%02h_done", b), done_bad, 0);
      check($sformatf("byte%02h_busy", b), busy_bad, 0);
      $display("terminal rx: %c (0x%02h)", rx, rx);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] b1, b2;
      int p, n;

      // Reset held across 3 edges
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_wready", wready, 1);
      check("rst_busy", busy, 0);
      check("rst_level", level, 0);
      check("rst_done", done, 0);

      // Single byte 'A' at prescale 15, with latency
      en = 1'b1;
      prescale = 16'd15;
      write_byte(8'h41);
      check("lat_n_tx", tx, 1);
      check("lat_n_level", level, 1);
      @(negedge clk);
      check("lat_n1_tx", tx, 1);
      @(negedge clk);
      expect_frame(8'h41, 15, 1'b1, -1, 16'd15, 1'b1);
      check("single_idle_busy", busy, 0);
      check("single_idle_level", level, 0);

      // Random single frames, including prescale 0
      for (int i = 0; i < 4; i++) begin
         p = (i == 0) ? 0 : int'($urandom_range(0, 4));
         b1 = 8'($urandom);
         parity_odd = 1'($urandom);
         prescale = 16'(p);
         write_byte(b1);
         expect_frame(b1, p, 1'b0, -1, 16'(p), 1'b1);
      end
      parity_odd = 1'b0;

      // Burst into a disabled transmitter: 17 writes, 16 accepted
      en = 1'b0;
      prescale = 16'd15;
      for (int i = 0; i < 17; i++) begin
         if (i == 16) begin
            check("full_level", level, 16);
            check("full_wready", wready, 0);
         end
         wdata  = 8'(i);
         wvalid = 1'b1;
         @(negedge clk);
      end
      wvalid = 1'b0;
      check("full_drop_level", level, 16);
      en = 1'b1;
      for (int i = 0; i < 16; i++) expect_frame(8'(i), 15, (i > 0), -1, 16'd15, 1'b1);
      check("burst_level_empty", level, 0);
      idle_check("burst_dropped_byte", 40);

      // Push landing on the pop edge with level 4
      en = 1'b0;
      p = int'($urandom_range(0, 3));
      prescale = 16'(p);
      for (int i = 0; i < 4; i++) begin
         q.push_back(8'($urandom));
         write_byte(q[$]);
      end
      check("pp_level_before", level, 4);
      q.push_back(8'($urandom));
      en = 1'b1;
      wdata = q[$];
      wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      check("pp_level_after", level, 4);
      n = 0;
      while (q.size() > 0) begin
         expect_frame(q.pop_front(), p, (n > 0), -1, 16'(p), 1'b1);
         n++;
      end

      // prescale changed mid-DATA: current frame keeps 16, next uses 4
      prescale = 16'd15;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      write_byte(b1);
      write_byte(b2);
      expect_frame(b1, 15, 1'b0, 40, 16'd3, 1'b1);
      expect_frame(b2, 3, 1'b1, -1, 16'd3, 1'b1);

      // en dropped mid-frame: frame completes, next waits
      prescale = 16'd2;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      write_byte(b1);
      write_byte(b2);
      expect_frame(b1, 2, 1'b0, 10, 16'd2, 1'b0);
      idle_check("en_off_hold", 30);
      check("en_off_level", level, 1);
      en = 1'b1;
      expect_frame(b2, 2, 1'b0, -1, 16'd2, 1'b1);

      // Reset during DATA
      prescale = 16'd15;
      for (int i = 0; i < 3; i++) write_byte(8'($urandom) & 8'h7e);
      n = 0;
      while (tx !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_start_seen", (n < 200), 1);
      repeat (40) @(negedge clk);
      check("rst_mid_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_tx", tx, 1);
      check("rst_mid_level", level, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_wready", wready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      idle_check("rst_mid_discard", 60);

`ifdef N5_UART_PARITY_EN
      parity_odd = 1'b0;
      write_byte(8'h07);
      expect_frame(8'h07, 15, 1'b0, -1, 16'd15, 1'b1);
      parity_odd = 1'b1;
      write_byte(8'h07);
      expect_frame(8'h07, 15, 1'b0, -1, 16'd15, 1'b1);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not finish, observed hang expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/n5_uart_tx.md
Name: n5_uart_tx

Overview:
- 8N1 UART transmitter with a byte FIFO.
- Sits in the N5 SoC UART0 path, directly upstream of the serial pin RsTx (io_out[21]); the bench terminal model decodes its output.
- Accepts bytes on a valid/ready write port, buffers them, and serializes each frame at a programmable bit period.
- Bench terminal default of 160 ns/bit at a 10 ns clock corresponds to prescale = 15.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
- PRESCALE_W, 16, width of the bit-period prescaler.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- en  in  1  transmitter enable; gates frame start only.
- prescale  in  PRESCALE_W  bit period minus one, in clocks.
- wdata  in  8  byte to enqueue.
- wvalid  in  1  write request.
- wready  out  1  FIFO not full.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset, asynchronous: tx=1, wready=1, busy=0, level=0, done=0, FSM=IDLE, all counters 0. Asserting reset mid-frame forces tx=1 immediately and discards the FIFO contents.
- Write handshake: a byte is pushed on the rising edge where wvalid & wready. wready is registered and equals !full. A write while full is dropped; no state changes.
- Push and pop on the same edge: level is unchanged and the pointers both advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if en & !empty, pop into shift register, load baud counter with prescale, go to START. prescale is sampled only here and held for the whole frame.
  - START: tx=0 for prescale+1 clocks, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts prescale+1 clocks; shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for prescale+1 clocks. done pulses on the final clock. Then go to IDLE, or go straight to START if en & !empty (back-to-back frames with no idle gap).
- Latency: a byte accepted on edge N into an empty FIFO while idle gives tx falling after edge N+2.
- Frame length is exactly 10*(prescale+1) clocks (11*(prescale+1) with parity).
- prescale=0 is legal: 1 clock per bit.
- en deasserted mid-frame: the current frame completes and the next frame does not start. en has no effect on writes.
- busy=1 in every state except IDLE.
- Pointers wrap modulo FIFO_DEPTH. level is tracked separately so the full and empty cases stay distinct.

Optional Feature:
- Macro N5_UART_PARITY_EN.
- When defined:
  - Adds input port parity_odd (1 bit).
  - Adds state PARITY between DATA and STOP.
  - tx = XOR of the 8 data bits, XORed with parity_odd, for prescale+1 clocks.
  - parity_odd is sampled at frame start.
- When undefined: no port, no state; the frame is strictly 8N1.

Decomposition:
- Package n5_uart_pkg holds:
  - the state encoding: IDLE=0, START=1, DATA=2, STOP=3, PARITY=4;
  - DATA_BITS=8;
  - the bit-index width.
- Sub-module n5_sync_fifo, parameterized by width and depth, provides push/pop, full/empty and level.
- The top holds the FSM, baud counter and shifter.

Test Plan:
- Reset check: hold wb_rst_i high across 3 edges, then release -> tx=1, wready=1, busy=0, level=0.
- Single byte: prescale=15, en=1, write 8'h41 -> tx low 16 clocks, then bits 1,0,0,0,0,0,1,0 each 16 clocks, then high 16 clocks. done pulses at clock 160 of the frame. Bench terminal prints "A".
- Burst and full: en=0, write 17 bytes 8'h00..8'h10 -> 16 accepted, level=16, wready=0, byte 8'h10 dropped. Then set en=1 -> 16 back-to-back frames with no idle gap, in order 00..0F, and level returns to 0.
- Simultaneous push/pop: with level=4, a write lands on the pop edge -> level stays 4 and the output order is preserved.
- Mid-frame events:
  - prescale changed from 15 to 3 during DATA -> the current frame stays at 16 clocks/bit and the next frame uses 4.
  - Reset asserted during DATA -> tx=1 within the same cycle and level=0.
- Parity build (N5_UART_PARITY_EN): byte 8'h07 with parity_odd=0 -> parity bit 1; with parity_odd=1 -> parity bit 0; frame length 176 clocks at prescale=15.
